muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the EX stage. Handles
//  MULT/MULTU/DIV/DIVU and writes a {hi,lo} result pair. Provides a busy
//  (stall-request) / done handshake so that EX can hold the instruction in
//  place until the result is ready. Adds annul (flush) and divide-by-zero
//  reporting. Replaces the fixed-width separate mul/div instances.
// PARAMETERS
//  WIDTH    32  operand width; hi and lo are each WIDTH bits
//  MUL_LAT  2   cycles spent in MUL state (>=1), models a pipelined multiplier
// PORTS
//  clk          in   1      rising-edge clock
//  resetn       in   1      asynchronous, active-low reset
//  start        in   1      request valid; EX holds it high while stalled
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src1         in   WIDTH  multiplicand / dividend (rs)
//  src2         in   WIDTH  multiplier / divisor (rt)
//  annul        in   1      flush: abort the operation in flight
//  busy         out  1      stall request to pipeline control
//  done         out  1      one-cycle pulse; hi/lo are valid
//  hi           out  WIDTH  product[2W-1:W] / remainder
//  lo           out  WIDTH  product[W-1:0] / quotient
//  div_by_zero  out  1      valid with done: divisor was 0
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; hi=lo=0; done=0; div_by_zero=0; busy=0.
//  FSM: IDLE -> MUL | DIV -> DONE -> IDLE.
//   IDLE: if start and no annul, latch op/src1/src2 and go to MUL (op[1]=0) or DIV.
//   MUL: count MUL_LAT cycles, then go to DONE. Signed ops sign-extend to
//     WIDTH+1 bits; unsigned ops zero-extend. The full 2W product is written.
//   DIV: radix-2 restoring divide on magnitudes, exactly WIDTH iterations,
//     then a sign fix on entry to DONE. Quotient is negative iff the operand
//     signs differ (signed op). Remainder takes the sign of the dividend.
//     lo=quotient, hi=remainder.
//   DONE: done=1 for one cycle and busy=0. start is ignored here because the
//     same instruction is still present in EX. Next state is IDLE.
//  busy = (IDLE & start & ~annul) | MUL | DIV. It is combinational, so EX
//   stalls in the same cycle it issues start.
//  Latency: start sampled in cycle 0. done in cycle MUL_LAT+1 (mul) or
//   WIDTH+1 (div, 33 at default).
//  Back-to-back: a new start in the cycle after DONE is accepted normally.
//  hi/lo are held from done until the next completed operation. An aborted
//   operation never alters hi/lo.
//  annul: from any state, go to IDLE next cycle with no done and busy=0 in
//   that cycle. If annul and start coincide in IDLE, the start is dropped.
//  Divisor 0: skip the iterations and reach DONE in cycle 1. Result:
//   lo={WIDTH{1}}, hi=src1, div_by_zero=1 with done. div_by_zero is 0 on
//   every other done.
//  Signed overflow (min_int / -1): lo=min_int (wraps), hi=0, no flag.
//  resetn deasserted mid-operation: immediate return to reset values and the
//   result is discarded.
// STRUCTURE
//  lib/defines.vh holds `MD_OP_MULT/MULTU/DIV/DIVU` encodings, the FSM state
//   encodings, and `MdBusy`/`MdIdle`.
//  One sub-module: div_core_radix2 (WIDTH param). It holds the iteration
//   counter and the partial-remainder/quotient shift registers, with ports
//   load/annul/ready. muldiv_unit keeps the FSM, the multiplier, sign
//   handling and the hi/lo registers.
// TESTING
//  1 MULT -3 x 5 -> hi=FFFFFFFF lo=FFFFFFF1; busy cycles 0..2; done in cycle 3.
//  2 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//  3 DIV -7 / 2 -> lo=FFFFFFFD hi=FFFFFFFF; done in cycle 33 only; then DIVU 7/2
//    started the following cycle -> lo=3 hi=1.
//  4 DIVU 100 / 0 -> done in cycle 1; lo=FFFFFFFF hi=00000064 div_by_zero=1.
//  5 DIV 80000000 / FFFFFFFF -> lo=80000000 hi=00000000 div_by_zero=0.
//  6 annul at iteration 10 of a DIVU -> no done; busy=0 next cycle; hi/lo keep
//    the test-5 values. resetn pulse mid-MUL -> hi=lo=0 with no done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encodings, FSM state type and op decode helpers for the multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MdIdle,
    MdMul,
    MdDiv,
    MdDone
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_core_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle, WIDTH cycles.
module div_core_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             active_q, active_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Partial remainder never exceeds the divisor, so bit WIDTH of diff is the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // The final iteration's result is exposed combinationally so the owner can
  // capture it on the same edge that retires it.
  assign ready     = active_q && (cnt_q == CntW'(WIDTH - 1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (annul) begin
      active_d = 1'b0;
    end else if (load) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
    end else if (active_q) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      cnt_d = cnt_q + 1'b1;
      if (ready) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for EX with busy/done handshake, annul and div-by-zero flag.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned LatW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e        state_q, state_d;
  logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             div_load;
  logic             div_ready;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;

  assign accept = (state_q == MdIdle) && start && !annul;

  // Extending straight to 2W bits is equivalent to a W+1-bit extension modulo 2^2W.
  always_comb begin
    mul_a   = {{WIDTH{sgn_q & src1_q[WIDTH-1]}}, src1_q};
    mul_b   = {{WIDTH{sgn_q & src2_q[WIDTH-1]}}, src2_q};
    product = mul_a * mul_b;
  end

  always_comb begin
    dvd_mag = (op_is_signed(op) && src1[WIDTH-1]) ? ('0 - src1) : src1;
    dvs_mag = (op_is_signed(op) && src2[WIDTH-1]) ? ('0 - src2) : src2;
    q_neg   = sgn_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
    r_neg   = sgn_q & src1_q[WIDTH-1];
  end

  assign div_load = accept && op_is_div(op) && (src2 != '0);

  div_core_radix2 #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .annul     (annul),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    sgn_d     = sgn_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    if (annul) begin
      state_d = MdIdle;
    end else begin
      unique case (state_q)
        MdIdle: begin
          if (start) begin
            sgn_d     = op_is_signed(op);
            src1_d    = src1;
            src2_d    = src2;
            lat_cnt_d = '0;
            if (!op_is_div(op)) begin
              state_d = MdMul;
            end else if (src2 == '0) begin
              state_d = MdDone;
              hi_d    = src1;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end else begin
              state_d = MdDiv;
            end
          end
        end
        MdMul: begin
          if (lat_cnt_q == LatW'(MUL_LAT - 1)) begin
            state_d = MdDone;
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            dbz_d   = 1'b0;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        MdDiv: begin
          if (div_ready) begin
            state_d = MdDone;
            hi_d    = r_neg ? ('0 - div_rem) : div_rem;
            lo_d    = q_neg ? ('0 - div_quo) : div_quo;
            dbz_d   = 1'b0;
          end
        end
        MdDone: begin
          state_d = MdIdle;
        end
        default: begin
          state_d = MdIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MdIdle;
      lat_cnt_q <= '0;
      sgn_q     <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      sgn_q     <= sgn_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = accept || (state_q == MdMul) || (state_q == MdDiv);
  assign done        = (state_q == MdDone);
  assign div_by_zero = dbz_q && (state_q == MdDone);
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random + directed bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          annul = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;

  muldiv_unit #(
    .WIDTH   (W),
    .MUL_LAT (LAT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .annul       (annul),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: language-level arithmetic, truncating signed divide.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    int     sa;
    int     sbv;
    e.dbz   = 1'b0;
    e.issue = 0;
    e.lat   = W + 1;
    e.hi    = '0;
    e.lo    = '0;
    sa      = a;
    sbv     = b;
    case (o)
      2'b00: begin
        p = longint'(sa) * longint'(sbv);
        {e.hi, e.lo} = p;
        e.lat = LAT + 1;
      end
      2'b01: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        {e.hi, e.lo} = p;
        e.lat = LAT + 1;
      end
      default: begin
        if (b == 0) begin
          e.lo  = '1;
          e.hi  = a;
          e.dbz = 1'b1;
          e.lat = 1;
        end else if (o == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = a;
            e.hi = '0;
          end else begin
            e.lo = sa / sbv;
            e.hi = sa % sbv;
          end
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done.
  always @(negedge clk) begin
    if (resetn && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_by_zero", div_by_zero, e.dbz);
        check("latency", cyc - e.issue, e.lat);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(o, a, b);
    e.issue = cyc;
    sb.push_back(e);
    op    = o;
    src1  = a;
    src2  = b;
    start = 1'b1;
    for (int k = 0; k <= e.lat; k++) begin
      @(negedge clk);
      check("busy", busy, (k < e.lat));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_no_done(input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(name, seen, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd7, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // Annul a DIVU at iteration 10: no done, busy drops, hi/lo untouched.
    op    = 2'b11;
    src1  = $urandom;
    src2  = 32'd3;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_busy", busy, 0);
    check("annul_done", done, 0);
    idle_no_done(40, "annul_no_done");
    check("annul_hi_kept", hi, 32'h0000_0000);
    check("annul_lo_kept", lo, 32'h8000_0000);

    // Start dropped when annul coincides with it in IDLE.
    op    = 2'b00;
    src1  = 32'd9;
    src2  = 32'd9;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    check("start_annul_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    idle_no_done(6, "start_annul_no_done");
    check("start_annul_lo_kept", lo, 32'h8000_0000);

    // Reset in the middle of a multiply.
    op    = 2'b00;
    src1  = 32'd3;
    src2  = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle_no_done(6, "midrst_no_done");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           sel;
      int           gap;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel < 3) b = W'($urandom_range(1, 20));
      else if (sel == 3) b = 32'hFFFF_FFFF;
      else b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_op(o, a, b);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
